// File: rtl/fetch_responder_pkg.sv
// fetch_responder_pkg: shared state encoding and reset fetch address
package fetch_responder_pkg;
  localparam logic [31:0] PC_RESET = 32'h0000_2000;
  typedef enum logic [1:0] {S_REQ, S_WAIT, S_VALID} state_t;
endpackage

// File: rtl/fetch_responder_if.sv
// fetch_responder_if: instruction-memory request/response channel
interface fetch_responder_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [ADDR_W-1:0] mem_req_addr;
  logic              mem_resp_valid;
  logic [DATA_W-1:0] mem_resp_data;
  modport master (output mem_req_valid, mem_req_addr, input mem_req_ready, mem_resp_valid, mem_resp_data);
  modport slave (input mem_req_valid, mem_req_addr, output mem_req_ready, mem_resp_valid, mem_resp_data);
endinterface

// File: rtl/fetch_responder.sv
// fetch_responder: fetches one instruction at a time and hands it to decode, dropping wrong-path words
module fetch_responder
  import fetch_responder_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(PC_RESET)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] next_pc,
  input  logic              redirect,
  output logic              fetch_stall,
  output logic [DATA_W-1:0] inst,
  output logic [ADDR_W-1:0] inst_pc,
  output logic              inst_valid,
  input  logic              dec_ready,
  fetch_responder_if.master mem
);
  state_t state, state_n;
  logic kill_q, kill_n;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] inst_q;
  logic handoff, addr_en, inst_en;
  assign handoff = state == S_VALID && dec_ready;
  assign addr_en = redirect || handoff;
  assign inst_en = state == S_WAIT && mem.mem_resp_valid && !kill_q && !redirect;
  assign mem.mem_req_valid = !reset && state == S_REQ;
  assign mem.mem_req_addr = {addr_q[ADDR_W-1:2], 2'b00};
  assign inst_valid = !reset && state == S_VALID;
  assign inst = inst_q;
  assign inst_pc = addr_q;
  assign fetch_stall = reset || !(handoff || redirect);
  always_comb begin
    state_n = state;
    kill_n = kill_q;
    unique case (state)
      S_REQ:
        if (mem.mem_req_ready) begin
          state_n = S_WAIT;
          kill_n = redirect;
        end
      S_WAIT:
        if (mem.mem_resp_valid) begin
          state_n = (kill_q || redirect) ? S_REQ : S_VALID;
          kill_n = 1'b0;
        end else if (redirect) begin
          kill_n = 1'b1;
        end
      S_VALID: state_n = (redirect || dec_ready) ? S_REQ : S_VALID;
      default: state_n = S_REQ;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_REQ;
      kill_q <= 1'b0;
    end else begin
      state <= state_n;
      kill_q <= kill_n;
    end
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      addr_q <= RESET_PC;
      inst_q <= '0;
    end else begin
      if (addr_en) addr_q <= next_pc;
      if (inst_en) inst_q <= mem.mem_resp_data;
    end
  end
endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: per-cycle vector table plus handoff scoreboard for fetch_responder
module tb_fetch_responder;
  typedef struct {
    logic [31:0] rst, rdr, npc, rdy, rsp, d, dec, good, sb;
    logic [31:0] mrv, maddr, iv, inst, ipc, stall;
  } vec_t;
  typedef struct {
    logic [31:0] inst, pc;
  } sb_t;
  logic clk = 1'b0;
  logic reset = 1'b1;
  logic [31:0] next_pc = '0;
  logic redirect = 1'b0;
  logic dec_ready = 1'b0;
  logic fetch_stall, inst_valid;
  logic [31:0] inst, inst_pc;
  int checks = 0;
  int errors = 0;
  vec_t tbl[$];
  sb_t sbq[$];
  fetch_responder_if #(.ADDR_W(32), .DATA_W(32)) bus ();
  fetch_responder dut (
    .clk(clk), .reset(reset), .next_pc(next_pc), .redirect(redirect),
    .fetch_stall(fetch_stall), .inst(inst), .inst_pc(inst_pc), .inst_valid(inst_valid),
    .dec_ready(dec_ready), .mem(bus)
  );
  always #5 clk = ~clk;
  function automatic vec_t mk(logic [31:0] rst, rdr, npc, rdy, rsp, d, dec, good, sb,
                              mrv, maddr, iv, ins, ipc, stall);
    vec_t t;
    t.rst = rst; t.rdr = rdr; t.npc = npc; t.rdy = rdy; t.rsp = rsp; t.d = d;
    t.dec = dec; t.good = good; t.sb = sb; t.mrv = mrv; t.maddr = maddr;
    t.iv = iv; t.inst = ins; t.ipc = ipc; t.stall = stall;
    return t;
  endfunction
  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask
  task automatic apply(input vec_t t, input string tag);
    @(posedge clk);
    #1;
    reset = t.rst[0];
    redirect = t.rdr[0];
    next_pc = t.npc;
    bus.mem_req_ready = t.rdy[0];
    bus.mem_resp_valid = t.rsp[0];
    bus.mem_resp_data = t.d;
    dec_ready = t.dec[0];
    if (t.good[0]) sbq.push_back('{inst: t.d, pc: t.sb});
    @(negedge clk);
    chk({tag, " mem_req_valid"}, 32'(bus.mem_req_valid), t.mrv);
    chk({tag, " inst_valid"}, 32'(inst_valid), t.iv);
    chk({tag, " fetch_stall"}, 32'(fetch_stall), t.stall);
    if (t.mrv[0]) chk({tag, " mem_req_addr"}, bus.mem_req_addr, t.maddr);
    if (t.iv[0]) begin
      chk({tag, " inst"}, inst, t.inst);
      chk({tag, " inst_pc"}, inst_pc, t.ipc);
    end
  endtask
  // every decode handoff must match the oldest good response; dropped words must never surface
  always @(negedge clk) begin
    if (!reset && inst_valid) begin
      chk("stale_word_visible", 32'(inst == 32'hDEADBEEF || inst == 32'hBADC0DE0 ||
                                    inst == 32'h00200113 || inst == 32'hCAFEF00D), 32'h0);
      if (dec_ready && !redirect) begin
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_underflow: handoff of %h with no expected word", inst);
        end else begin
          sb_t e;
          e = sbq.pop_front();
          chk("sb_inst", inst, e.inst);
          chk("sb_inst_pc", inst_pc, e.pc);
        end
      end
    end
  end
  initial begin
    int lows;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    bus.mem_resp_data = '0;
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            1, 'h2000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h13, 0, 1, 'h2000,    0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 'h2004, 0, 0, 0, 1, 0, 0,       0, 0, 1, 'h13, 'h2000, 0));
    for (int i = 0; i < 3; i++)
      tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,          1, 'h2004, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            1, 'h2004, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h00100093, 0, 1, 'h2004, 0, 0, 0, 0, 0, 1));
    for (int i = 0; i < 4; i++)
      tbl.push_back(mk(0, 0, 'h2008, 0, 0, 0, 0, 0, 0,     0, 0, 1, 'h00100093, 'h2004, 1));
    tbl.push_back(mk(0, 0, 'h2008, 0, 0, 0, 1, 0, 0,       0, 0, 1, 'h00100093, 'h2004, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            1, 'h2008, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 'h3000, 0, 0, 0, 0, 0, 0,       0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'hDEADBEEF, 0, 0, 0,   0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            1, 'h3000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 'h4000, 0, 1, 'h00200113, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    tbl.push_back(mk(0, 1, 'h5000, 1, 0, 0, 0, 0, 0,       1, 'h4000, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'hBADC0DE0, 0, 0, 0,   0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            1, 'h5000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h00300193, 0, 1, 'h5000, 0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 'h5004, 0, 0, 0, 1, 0, 0,       0, 0, 1, 'h00300193, 'h5000, 0));
    tbl.push_back(mk(0, 1, 'h6002, 0, 0, 0, 0, 0, 0,       1, 'h5004, 0, 0, 0, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            1, 'h6000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h00400213, 0, 0, 0,   0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 1, 'h7000, 0, 0, 0, 0, 0, 0,       0, 0, 1, 'h00400213, 'h6002, 0));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            1, 'h7000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0,            0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'hCAFEF00D, 0, 0, 0,   1, 'h2000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 1, 0, 0, 0, 0, 0,            1, 'h2000, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 0, 0, 1, 'h13, 0, 1, 'h2000,    0, 0, 0, 0, 0, 1));
    tbl.push_back(mk(0, 0, 'h2004, 0, 0, 0, 1, 0, 0,       0, 0, 1, 'h13, 'h2000, 0));
    tbl.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0,            1, 'h2004, 0, 0, 0, 1));
    foreach (tbl[i]) apply(tbl[i], $sformatf("v%0d", i));
    // zero-wait streaming: one instruction every three cycles
    lows = 0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] pc, w;
      pc = 32'h2004 + 32'(i * 4);
      w = 32'h00A00093 + 32'(i);
      apply(mk(0, 0, 0, 1, 0, 0, 0, 0, 0, 1, pc, 0, 0, 0, 1), $sformatf("s%0d_req", i));
      lows += int'(!fetch_stall);
      apply(mk(0, 0, 0, 0, 1, w, 0, 1, pc, 0, 0, 0, 0, 0, 1), $sformatf("s%0d_resp", i));
      lows += int'(!fetch_stall);
      apply(mk(0, 0, pc + 4, 0, 0, 0, 1, 0, 0, 0, 0, 1, w, pc, 0), $sformatf("s%0d_hand", i));
      lows += int'(!fetch_stall);
    end
    chk("stream_stall_low_cycles", 32'(lows), 32'd4);
    @(posedge clk);
    #1;
    dec_ready = 1'b0;
    bus.mem_req_ready = 1'b0;
    bus.mem_resp_valid = 1'b0;
    @(negedge clk);
    chk("sb_drained", 32'(sbq.size()), 32'd0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule

// File: doc/fetch_responder.md
Name: fetch_responder

Overview:
- Responder side of the instruction-fetch interface. Consumes the PC unit's next_pc and fetches the instruction word from a variable-latency instruction memory over a valid/ready request and valid response channel.
- Presents the instruction and its PC to decode.
- Drives the stall back into the PC register.
- Discards wrong-path fetches when the core redirects.

Parameters:
- ADDR_W, 32, fetch address width
- DATA_W, 32, instruction word width
- RESET_PC, 32'h00002000, first fetch address after reset

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- next_pc  in  ADDR_W  next PC from PC unit; already reflects any redirect
- redirect  in  1  PC unit is taking a branch/jump target this cycle
- fetch_stall  out  1  holds the PC register (drives its stall input)
- inst  out  DATA_W  fetched instruction
- inst_pc  out  ADDR_W  address of inst
- inst_valid  out  1  inst/inst_pc valid for decode
- dec_ready  in  1  decode accepts inst this cycle
- mem_req_valid  out  1  memory request valid
- mem_req_ready  in  1  memory accepts request
- mem_req_addr  out  ADDR_W  word-aligned request address
- mem_resp_valid  in  1  response data valid, one cycle, exactly one per accepted request
- mem_resp_data  in  DATA_W  response word

Behaviour:
- Clock and reset: one clock, clk. reset is synchronous and active-high.
- State registers: state (S_REQ, S_WAIT, S_VALID), addr_q, inst_q, kill_q.
- Reset values:
  - state=S_REQ, addr_q=RESET_PC, kill_q=0, inst_q=0.
  - During the reset cycle: mem_req_valid=0, inst_valid=0, fetch_stall=1.
- Address alignment: mem_req_addr={addr_q[ADDR_W-1:2],2'b00}. inst_pc=addr_q.
- S_REQ:
  - mem_req_valid=1.
  - On mem_req_ready -> S_WAIT.
- S_WAIT:
  - mem_req_valid=0.
  - On mem_resp_valid with kill_q=0: inst_q<=mem_resp_data, go S_VALID.
  - On mem_resp_valid with kill_q=1: drop data, clear kill_q, go S_REQ.
- S_VALID:
  - inst_valid=1.
  - On dec_ready (handoff): addr_q<=next_pc, go S_REQ.
  - Without dec_ready: hold inst/inst_pc stable.
- fetch_stall = !((state==S_VALID & dec_ready) | redirect). The PC advances exactly on handoff or redirect.
- Redirect, all states: addr_q<=next_pc. Then, per state:
  - S_REQ without ready: stay S_REQ; the new address goes out next cycle.
  - S_REQ with ready the same cycle: the old request is in flight. Go S_WAIT, kill_q<=1.
  - S_WAIT without resp: kill_q<=1.
  - S_WAIT with resp the same cycle: drop data, go S_REQ.
  - S_VALID: drop inst, go S_REQ. inst_valid may still be 1 this cycle; decode squashes on redirect.
- Request rules:
  - At most one outstanding request.
  - mem_req_addr stays stable while mem_req_valid & !mem_req_ready, except on redirect. Redirect may change the address before acceptance.
- Latency: minimum is handoff -> S_REQ (1) -> accept -> S_WAIT -> resp -> S_VALID, so one instruction per 3 cycles with zero-wait memory.
- Reset mid-operation: immediate return to reset values. A response arriving after reset with no request outstanding is ignored; S_REQ does not sample mem_resp_valid.

Decomposition:
- Shared package / const header: state encoding localparams (S_REQ, S_WAIT, S_VALID) and the PC_RESET constant (RESET_PC defaults to it).
- Single module. Registers use the codebase's REGISTER_R_CE primitives: addr_q and inst_q with enables, state and kill_q with reset.
- No sub-module needed.

Test Plan:
- Reset, then mem_req_ready=1 and 1-cycle response 32'h00000013, dec_ready=1 -> first mem_req_addr=32'h00002000, inst=32'h00000013, inst_pc=32'h00002000, fetch_stall low exactly one cycle, next request at 32'h00002004.
- mem_req_ready low 3 cycles -> mem_req_valid and mem_req_addr held at 32'h00002004, fetch_stall high throughout.
- dec_ready low 4 cycles in S_VALID -> inst and inst_pc stable, no new request, fetch_stall high. dec_ready high -> one handoff.
- Redirect in S_WAIT with next_pc=32'h00003000, response 32'hDEADBEEF arriving 2 cycles later -> inst_valid never shows DEADBEEF, next request at 32'h00003000.
- Redirect in the same cycle as mem_resp_valid, and redirect in the same cycle as mem_req_ready -> stale word dropped in both cases, next accepted request addr = redirect target, kill_q clear afterwards.
- Reset asserted in S_WAIT -> next cycle state S_REQ, addr 32'h00002000, inst_valid 0. A late mem_resp_valid is ignored.
